// File: rtl/mux_sweep_pkg.sv
// Shared definitions for the mux sweep checker.
//   state_t   : sweep controller states (IDLE, RUN, DONE)
//   VEC_COUNT : number of input vectors of a three-input mux (2**3)
//   IDX_W     : width of the vector index
package mux_sweep_pkg;

    localparam int VEC_COUNT = 8;
    localparam int IDX_W     = $clog2(VEC_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_sweep_timer.sv
// Settle counter for the mux sweep checker. Counts clocks while a vector
// is held on the mux inputs and flags the clock on which OUT is sampled.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear of the count (wins over enable)
//   enable : count this clock
//   tc     : terminal count, high while the count equals SETTLE_CYCLES-1
module mux_sweep_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("mux_sweep_timer: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt;

    assign tc = (cnt == LAST);

    // The count wraps to zero on the terminal clock so that every vector
    // is held for exactly SETTLE_CYCLES clocks without an extra gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? 8'd0 : cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mux_sweep_checker.sv
// Sweeps all eight input vectors of a three-variable mux, waits
// SETTLE_CYCLES clocks per vector, captures OUT into a truth table and
// compares it with a golden table latched at start.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request a sweep (acted on only in IDLE)
//   abort               : cancel a running sweep (wins over start)
//   expected[7:0]       : golden table, bit i = expected OUT for vector i
//   mux_out             : OUT of the mux under test
//   sel_a, sel_b, sel_c : registered mux inputs, sel_a is the vector MSB
//   busy                : sweep in progress
//   done                : one-cycle pulse on sweep completion
//   pass                : last completed sweep matched the golden table
//   table_out[7:0]      : captured truth table
//   mismatch[7:0]       : table_out XOR latched golden table
//   state_dbg[1:0]      : controller state (state_t encoding)
//
// Control handshake: start is a level request sampled on each rising edge
// and only accepted when the controller is IDLE and abort is low; there is
// no acknowledge other than busy rising. abort is sampled on each rising
// edge and cancels a RUN immediately; in IDLE it only suppresses start.
module mux_sweep_checker
    import mux_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       mux_out,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] table_out,
    output logic [7:0] mismatch,
    output logic [1:0] state_dbg
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("mux_sweep_checker: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(VEC_COUNT - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       index;
    logic [IDX_W-1:0]       sel_q;
    logic [VEC_COUNT-1:0]   exp_lat;
    logic [VEC_COUNT-1:0]   table_nxt;
    logic                   tc;
    logic                   start_ok;
    logic                   run_abort;
    logic                   sample;
    logic                   last_vec;

    assign start_ok  = (state == IDLE) && start && !abort;
    assign run_abort = (state == RUN) && abort;
    assign sample    = (state == RUN) && !abort && tc;
    assign last_vec  = (index == LAST_VEC);

    assign sel_a     = sel_q[2];
    assign sel_b     = sel_q[1];
    assign sel_c     = sel_q[0];
    assign state_dbg = state;

    mux_sweep_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_ok | run_abort),
        .enable (state == RUN),
        .tc     (tc)
    );

    // Table as it will look after this clock's capture; pass and mismatch
    // on the final vector must include the bit being written right now.
    always_comb begin
        table_nxt        = table_out;
        table_nxt[index] = mux_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tc && last_vec) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index     <= '0;
            sel_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            mismatch  <= '0;
            exp_lat   <= '0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                exp_lat   <= expected;
                table_out <= '0;
                index     <= '0;
                sel_q     <= '0;
                busy      <= 1'b1;
            end else if (run_abort) begin
                // Partial captures stay visible in table_out.
                busy  <= 1'b0;
                sel_q <= '0;
                pass  <= 1'b0;
            end else if (sample) begin
                table_out <= table_nxt;
                if (last_vec) begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    sel_q    <= '0;
                    pass     <= (table_nxt == exp_lat);
                    mismatch <= table_nxt ^ exp_lat;
                end else begin
                    index <= index + 1'b1;
                    sel_q <= index + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Three-variable mux used as the device exercised by the checker.
module threevarMUX (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic OUT
);
    assign OUT = A ? C : B;
endmodule

// Bench for mux_sweep_checker: one instance with SETTLE_CYCLES=4 and one
// with SETTLE_CYCLES=1 share start/abort/expected; each drives its own mux.
module tb_mux_sweep_checker;

    localparam int S0 = 4;
    localparam int S1 = 1;
    int s_of[2] = '{S0, S1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       tbl_mode = 1'b0;   // 1: mux_out comes from rnd_tbl
    logic [7:0] rnd_tbl  = 8'h00;
    logic       noise_en = 1'b0;
    bit         noise[2];

    logic       sel_a_w[2], sel_b_w[2], sel_c_w[2];
    logic       busy_w[2], done_w[2], pass_w[2];
    logic       mux_y[2], mux_out_w[2];
    logic [7:0] table_w[2], mis_w[2];
    logic [1:0] state_w[2];

    for (genvar k = 0; k < 2; k++) begin : g_mux
        logic [2:0] v;
        assign v = {sel_a_w[k], sel_b_w[k], sel_c_w[k]};
        threevarMUX u_mux (.A(sel_a_w[k]), .B(sel_b_w[k]), .C(sel_c_w[k]), .OUT(mux_y[k]));
        assign mux_out_w[k] = (tbl_mode ? rnd_tbl[v] : mux_y[k]) ^ noise[k];
    end

    mux_sweep_checker #(.SETTLE_CYCLES(S0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .mux_out(mux_out_w[0]), .sel_a(sel_a_w[0]), .sel_b(sel_b_w[0]), .sel_c(sel_c_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .table_out(table_w[0]),
        .mismatch(mis_w[0]), .state_dbg(state_w[0])
    );

    mux_sweep_checker #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .mux_out(mux_out_w[1]), .sel_a(sel_a_w[1]), .sel_b(sel_b_w[1]), .sel_c(sel_c_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .table_out(table_w[1]),
        .mismatch(mis_w[1]), .state_dbg(state_w[1])
    );

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h at t=%0t", nm, inst, act, exp, $time);
    endtask

    function automatic logic [2:0] sel_of(input int k);
        return {sel_a_w[k], sel_b_w[k], sel_c_w[k]};
    endfunction

    // Noise-free OUT for vector v, straight from the mux definition.
    function automatic bit ref_out(input int v);
        bit [2:0] b;
        b = 3'(v);
        if (tbl_mode) return rnd_tbl[b];
        return b[2] ? b[0] : b[1];
    endfunction

    function automatic bit [7:0] ref_table();
        bit [7:0] r;
        for (int v = 0; v < 8; v++) r[v] = ref_out(v);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // A sweep is described by the edge it started on: edge e after the start
    // edge is a sample edge when e is a multiple of S, capturing vector e/S-1.
    int       cyc = 0;
    bit       m_run[2], m_done[2], m_pass[2];
    bit [7:0] m_tab[2], m_exp[2], m_mis[2];
    int       m_start[2], m_sel[2];

    always @(posedge clk or negedge rst_n) begin
        bit was_done;
        int e;
        int v;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_done[k] = 0; m_pass[k] = 0;
                m_tab[k] = 0; m_exp[k] = 0; m_mis[k] = 0; m_sel[k] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < 2; k++) begin
                was_done  = m_done[k];
                m_done[k] = 0;
                if (m_run[k]) begin
                    e = cyc - m_start[k];
                    if (abort) begin
                        m_run[k]  = 0;
                        m_pass[k] = 0;
                    end else if (e % s_of[k] == 0) begin
                        v = e / s_of[k] - 1;
                        m_tab[k][v] = ref_out(v);
                        if (v == 7) begin
                            m_run[k]  = 0;
                            m_done[k] = 1;
                            m_pass[k] = (m_tab[k] == m_exp[k]);
                            m_mis[k]  = m_tab[k] ^ m_exp[k];
                        end
                    end
                end else if (!was_done && start && !abort) begin
                    m_run[k]   = 1;
                    m_start[k] = cyc;
                    m_exp[k]   = expected;
                    m_tab[k]   = 0;
                end
                m_sel[k] = m_run[k] ? (cyc - m_start[k]) / s_of[k] : 0;
            end
        end
    end

    // Glitches on mux_out only on clocks whose next edge is not a sample edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (noise_en && !(m_run[k] && ((cyc + 1 - m_start[k]) % s_of[k] == 0)))
                noise[k] = bit'($urandom_range(0, 1));
            else
                noise[k] = 0;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("busy",     k, 32'(busy_w[k]),  32'(m_run[k]));
            chk("done",     k, 32'(done_w[k]),  32'(m_done[k]));
            chk("pass",     k, 32'(pass_w[k]),  32'(m_pass[k]));
            chk("sel",      k, 32'(sel_of(k)),  32'(m_sel[k]));
            chk("table",    k, 32'(table_w[k]), 32'(m_tab[k]));
            chk("mismatch", k, 32'(mis_w[k]),   32'(m_mis[k]));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic pulse_start(output int s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done0(input int s, output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done_w[0]) begin
                lat = cyc - s;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int s;
        int lat;
        int n;
        int off;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  0, 32'(busy_w[0]),  32'd0);
        chk("rst_sel",   0, 32'(sel_of(0)),  32'd0);
        chk("rst_table", 0, 32'(table_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Golden table matches the A?C:B mux.
        expected = 8'hAC;
        pulse_start(s);
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) chk("s1_sel_step", 1, 32'(sel_of(1)), 32'(k));
            else begin
                chk("s1_done_at_8", 1, 32'(done_w[1]), 32'd1);
                chk("s1_pass",      1, 32'(pass_w[1]), 32'd1);
            end
            @(negedge clk);
        end
        wait_done0(s, lat);
        chk("a_latency", 0, 32'(lat),         32'd32);
        chk("a_pass",    0, 32'(pass_w[0]),   32'd1);
        chk("a_table",   0, 32'(table_w[0]),  32'hAC);
        chk("a_mism",    0, 32'(mis_w[0]),    32'h00);
        @(negedge clk);
        chk("a_done_1cyc", 0, 32'(done_w[0]), 32'd0);

        // Golden table off by one bit.
        expected = 8'hAD;
        pulse_start(s);
        wait_done0(s, lat);
        chk("b_latency", 0, 32'(lat),        32'd32);
        chk("b_pass",    0, 32'(pass_w[0]),  32'd0);
        chk("b_mism",    0, 32'(mis_w[0]),   32'h01);
        chk("b_table",   0, 32'(table_w[0]), 32'hAC);
        @(negedge clk);

        // Extra start pulses at clocks 5 and 20 of the sweep.
        expected = 8'hAC;
        pulse_start(s);
        n = 0;
        lat = -1;
        for (int i = 0; i < 45; i++) begin
            off = cyc - s;
            start = (off == 4 || off == 19);
            if (done_w[0]) begin
                n++;
                lat = off;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("c_done_count", 0, 32'(n),         32'd1);
        chk("c_latency",    0, 32'(lat),       32'd32);
        chk("c_pass",       0, 32'(pass_w[0]), 32'd1);
        repeat (12) @(negedge clk);

        // Abort at clock 10 of RUN, with a table that makes bits [1:0] visible.
        tbl_mode = 1'b1;
        rnd_tbl  = 8'h5B;
        expected = 8'h5B;
        pulse_start(s);
        repeat (9) @(negedge clk);
        chk("d_sel_before", 0, 32'(sel_of(0)), 32'd2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("d_busy",  0, 32'(busy_w[0]),  32'd0);
        chk("d_sel",   0, 32'(sel_of(0)),  32'd0);
        chk("d_done",  0, 32'(done_w[0]),  32'd0);
        chk("d_pass",  0, 32'(pass_w[0]),  32'd0);
        chk("d_table", 0, 32'(table_w[0]), 32'h03);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_w[0]) n++;
            @(negedge clk);
        end
        chk("d_no_done", 0, 32'(n), 32'd0);

        // Asynchronous reset mid-sweep, then a fresh sweep.
        tbl_mode = 1'b0;
        expected = 8'hAC;
        pulse_start(s);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("e_busy",  k, 32'(busy_w[k]),  32'd0);
            chk("e_done",  k, 32'(done_w[k]),  32'd0);
            chk("e_pass",  k, 32'(pass_w[k]),  32'd0);
            chk("e_sel",   k, 32'(sel_of(k)),  32'd0);
            chk("e_table", k, 32'(table_w[k]), 32'd0);
            chk("e_mism",  k, 32'(mis_w[k]),   32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(s);
        wait_done0(s, lat);
        chk("e_latency", 0, 32'(lat),        32'd32);
        chk("e_pass2",   0, 32'(pass_w[0]),  32'd1);
        chk("e_table2",  0, 32'(table_w[0]), 32'hAC);
        @(negedge clk);

        // Randomized traffic with glitches between sample edges.
        noise_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 59) == 0);
            if (!m_run[0] && !m_run[1] && !m_done[0] && !m_done[1] && $urandom_range(0, 7) == 0) begin
                tbl_mode = 1'($urandom_range(0, 1));
                rnd_tbl  = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3) == 0)
                expected = ($urandom_range(0, 1) == 1) ? ref_table() : 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        start    = 1'b0;
        abort    = 1'b0;
        noise_en = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
